// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle
// on operand magnitudes, a final sign fix-up, and a single-cycle path for divide corner cases.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]  tag_out
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned W2 = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           f3_q, f3_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [W-1:0]         mcand_q, mcand_d;
    logic [W2-1:0]        acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [W-1:0]         result_q, result_d;
    logic [TAG_WIDTH-1:0] tag_out_q, tag_out_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    // Operand decode at acceptance: signedness, magnitudes and corner cases
    logic         sgn_a, sgn_b;
    logic [W-1:0] mag_a, mag_b;
    logic         b_zero, div_ovf;

    always_comb begin
        sgn_a   = (funct3 == F_MULH || funct3 == F_MULHSU || funct3 == F_DIV || funct3 == F_REM)
                  && op_a[W-1];
        sgn_b   = (funct3 == F_MULH || funct3 == F_DIV || funct3 == F_REM) && op_b[W-1];
        mag_a   = sgn_a ? (~op_a + W'(1)) : op_a;
        mag_b   = sgn_b ? (~op_b + W'(1)) : op_b;
        b_zero  = (op_b == '0);
        div_ovf = funct3[2] && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
    end

    // One iteration of shift-add multiply and restoring divide
    logic [W:0]    mul_sum;
    logic [W2-1:0] mul_next;
    logic [W:0]    trial, diff;
    logic [W2-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : (W+1)'(0));
        mul_next = {mul_sum, acc_q[W-1:1]};
        trial    = acc_q[W2-1:W-1];
        diff     = trial - {1'b0, mcand_q};
        div_next = diff[W] ? {trial[W-1:0], acc_q[W-2:0], 1'b0}
                           : {diff[W-1:0], acc_q[W-2:0], 1'b1};
    end

    // Sign fix-up and output selection
    logic [W2-1:0] prod_fix;
    logic [W-1:0]  quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = neg_q ? (~acc_q + W2'(1)) : acc_q;
        quo_fix  = neg_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
        rem_fix  = neg_q ? (~acc_q[W2-1:W] + W'(1)) : acc_q[W2-1:W];
        case (f3_q)
            F_MUL:                      fix_res = prod_fix[W-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fix_res = prod_fix[W2-1:W];
            F_DIV, F_DIVU:              fix_res = quo_fix;
            default:                    fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        tag_d     = tag_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;
        done_d    = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        f3_d  = funct3;
                        tag_d = tag_in;
                        if (funct3[2] && b_zero) begin
                            result_d  = funct3[1] ? op_a : '1;
                            tag_out_d = tag_in;
                            done_d    = 1'b1;
                        end else if (div_ovf) begin
                            result_d  = funct3[1] ? '0 : op_a;
                            tag_out_d = tag_in;
                            done_d    = 1'b1;
                        end else begin
                            state_d = S_CALC;
                            cnt_d   = '0;
                            if (funct3[2]) begin
                                mcand_d = mag_b;
                                acc_d   = {{W{1'b0}}, mag_a};
                                neg_d   = funct3[1] ? sgn_a : (sgn_a ^ sgn_b);
                            end else begin
                                mcand_d = mag_a;
                                acc_d   = {{W{1'b0}}, mag_b};
                                neg_d   = sgn_a ^ sgn_b;
                            end
                        end
                    end
                end
                S_CALC: begin
                    acc_d = f3_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d  = fix_res;
                    tag_out_d = tag_q;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            tag_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            tag_out_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            tag_q     <= tag_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign tag_out = tag_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (DATA_WIDTH=32): hand-computed results, latencies,
// corner cases, flush, back-to-back issue and asynchronous reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  tag_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  tag_out;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .flush   (flush),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .tag_in  (tag_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .tag_out (tag_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request; caller is at a falling edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        tag_in = t;
        start  = 1'b1;
    endtask

    // Wait for done, scrambling the inputs right after acceptance; ends in the done cycle
    task automatic wait_done(input string name, input logic [31:0] exp_res,
                             input logic [4:0] exp_tag, input int exp_lat);
        int lat       = 0;
        bit seen      = 1'b0;
        bit busy_seen = 1'b0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start  = 1'b0;
                op_a   = $urandom;
                op_b   = $urandom;
                funct3 = 3'($urandom_range(7, 0));
                tag_in = 5'($urandom_range(31, 0));
            end
            if (busy) busy_seen = 1'b1;
            if (done) seen = 1'b1;
        end
        check_eq({name, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({name, " result"}, 64'(result), 64'(exp_res));
        check_eq({name, " tag"}, 64'(tag_out), 64'(exp_tag));
        check_eq({name, " busy"}, 64'(busy_seen), 64'(exp_lat != 1));
    endtask

    initial begin
        int dones;
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        tag_in = '0;
        repeat (2) @(negedge clk);
        check_eq("reset busy", 64'(busy), 64'(0));
        check_eq("reset done", 64'(done), 64'(0));
        check_eq("reset result", 64'(result), 64'(0));
        check_eq("reset tag", 64'(tag_out), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_done("mul", 32'hFFFF_FFEB, 5'd5, 34);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1);
        wait_done("mulh", 32'h4000_0000, 5'd1, 34);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        wait_done("mulhu", 32'hFFFF_FFFE, 5'd2, 34);
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3);
        wait_done("mulhsu", 32'hFFFF_FFFF, 5'd3, 34);

        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10);
        wait_done("div", 32'hFFFF_FFFD, 5'd10, 34);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11);
        wait_done("rem", 32'hFFFF_FFFF, 5'd11, 34);
        issue(3'b101, 32'd100, 32'd7, 5'd12);
        wait_done("divu", 32'd14, 5'd12, 34);
        issue(3'b111, 32'd100, 32'd7, 5'd13);
        wait_done("remu", 32'd2, 5'd13, 34);

        issue(3'b101, 32'd123, 32'd0, 5'd20);
        wait_done("divu by 0", 32'hFFFF_FFFF, 5'd20, 1);
        issue(3'b110, 32'd123, 32'd0, 5'd21);
        wait_done("rem by 0", 32'd123, 5'd21, 1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22);
        wait_done("div ovf", 32'h8000_0000, 5'd22, 1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23);
        wait_done("rem ovf", 32'd0, 5'd23, 1);

        // Back-to-back: second request driven in the first one's done cycle
        issue(3'b101, 32'd100, 32'd7, 5'd3);
        wait_done("b2b first", 32'd14, 5'd3, 34);
        check_eq("b2b idle in done", 64'(busy), 64'(0));
        issue(3'b000, 32'd6, 32'd7, 5'd4);
        wait_done("b2b second", 32'd42, 5'd4, 34);

        // Flush ten cycles into a divide
        issue(3'b100, 32'd100, 32'd7, 5'd9);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        check_eq("flush busy before", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush busy after", 64'(busy), 64'(0));
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("flush no done", 64'(dones), 64'(0));
        check_eq("flush result kept", 64'(result), 64'(42));
        check_eq("flush tag kept", 64'(tag_out), 64'(4));

        // Start coincident with flush is ignored
        issue(3'b101, 32'd5, 32'd0, 5'd17);
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check_eq("start+flush busy", 64'(busy), 64'(0));
        check_eq("start+flush done", 64'(done), 64'(0));
        check_eq("start+flush result", 64'(result), 64'(42));

        // Asynchronous reset mid-calculation
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
        repeat (5) @(negedge clk);
        start = 1'b0;
        check_eq("pre-reset busy", 64'(busy), 64'(1));
        #2 rst = 1'b1;
        #1;
        check_eq("async reset busy", 64'(busy), 64'(0));
        check_eq("async reset done", 64'(done), 64'(0));
        check_eq("async reset result", 64'(result), 64'(0));
        check_eq("async reset tag", 64'(tag_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(3'b111, 32'd100, 32'd7, 5'd7);
        wait_done("post-reset remu", 32'd2, 5'd7, 34);

        @(negedge clk);
        check_eq("done is pulse", 64'(done), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits beside the ALU in the Execute stage. The core stalls its pipeline while `busy` is high and captures `result` and `tag_out` when `done` pulses.
- Data width is parametrised. Operates 1 bit per cycle on operand magnitudes, with sign fix-up at the end.
- Handles the RISC-V corner cases (divide by zero, signed overflow) on a 1-cycle fast path.
- Supports a flush input so a mispredicted branch can abort an in-flight operation.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits; must be ≥ 4 and even.
- TAG_WIDTH, 5, width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only when busy=0.
- flush  in  1  synchronous abort of any in-flight operation; has priority over start.
- funct3  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  DATA_WIDTH  rs1 operand (dividend / multiplicand).
- op_b  in  DATA_WIDTH  rs2 operand (divisor / multiplier).
- tag_in  in  TAG_WIDTH  destination register index, captured with the operands.
- busy  out  1  unit occupied; start is ignored while high.
- done  out  1  one-cycle pulse; result and tag_out are valid in this cycle.
- result  out  DATA_WIDTH  operation result; held until the next done.
- tag_out  out  TAG_WIDTH  tag captured at acceptance.

Behaviour:
- Reset (rst=1, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0, tag_out=0.
  - All internal counters and accumulators are cleared.
- States and transitions:
  - IDLE -> CALC on acceptance (start=1 & flush=0 & busy=0) at edge E0, unless a fast case applies.
  - CALC -> FIX after DATA_WIDTH iterations.
  - FIX -> IDLE.
  - busy = (state != IDLE).
- Acceptance at E0 registers:
  - funct3 and tag_in.
  - Operand magnitudes: signed-interpreted operands are negated if negative.
    - MULH, DIV, REM: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - MULHU, DIVU, REMU: both operands unsigned.
    - MUL: treated as unsigned (the low half is sign-independent).
  - The result sign flag:
    - multiply: sign_a ^ sign_b;
    - DIV: sign_a ^ sign_b;
    - REM: sign_a.
  - Iteration counter = 0.
- CALC, edges E1..E_DATA_WIDTH, one step per edge:
  - Multiply: shift-add into a 2*DATA_WIDTH-bit accumulator.
  - Divide: restoring step (shift remainder, trial-subtract divisor, set quotient bit).
- FIX (edge E_DATA_WIDTH+1):
  - Negate the product, quotient or remainder if the sign flag is set.
  - Select the output: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register result and tag_out; done=1 for exactly the following cycle.
  - Normal latency: done is high in the cycle after edge E_DATA_WIDTH+1 (DATA_WIDTH+2 cycles after the accept cycle).
- Fast cases, decided at E0: result and done are registered at E0, state stays IDLE, done is high in the next cycle.
  - DIV/DIVU with op_b=0: result = all ones.
  - REM/REMU with op_b=0: result = op_a.
  - DIV with op_a = most-negative and op_b = all ones (-1): result = op_a.
  - REM with op_a = most-negative and op_b = -1: result = 0.
- done is a pulse: it is cleared on the next edge unless a new completion occurs on that edge.
- In the done cycle busy=0, so a start in that same cycle is accepted (back-to-back issue, no bubble).
- flush=1 at any edge:
  - state -> IDLE and the operation is discarded.
  - done=0 on that edge; no done is ever produced for the aborted operation.
  - result and tag_out keep their previous values.
  - A start coincident with flush is ignored.
- Changes on op_a, op_b, funct3 or tag_in after acceptance have no effect.
- Widths: every negation is two's complement modulo 2^DATA_WIDTH (2^(2*DATA_WIDTH) for the product); no overflow flag is produced.

Test Plan (DATA_WIDTH=32):
- Reset state: rst pulse mid-CALC -> busy=0, done=0, result=0 immediately (asynchronously); next start behaves normally.
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done exactly 34 cycles after the accept cycle; tag_out echoes tag_in=5.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- Signed divide/remainder: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Corner cases (each done 1 cycle after accept, busy never high):
  - DIVU 123/0 -> 0xFFFFFFFF.
  - REM 123/0 -> 123.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Flush and back-to-back:
  - flush 10 cycles into a DIV -> no done, busy drops next cycle.
  - start asserted in a done cycle -> accepted with zero-cycle gap, second result correct.
  - start+flush together -> ignored.
